// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-access stage: access-size encodings,
// the stage FSM state type and the byte-enable patterns used for stores.
// No ports.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // The reserved size code 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] effective_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Data-memory request/acknowledge bus between the memory-access stage and
// the data memory.
//   master (stage) : drives dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be;
//                    receives dmem_ack, dmem_rdata.
//   slave (memory) : the mirror image.
interface mem_access_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// mem_load_align
// Combinational load-data aligner: picks the addressed byte/half out of the
// 32-bit read word and sign- or zero-extends it; words pass unchanged.
//   rdata       in  32  read word from data memory
//   size        in  2   effective access size (byte/half/word)
//   offset      in  2   alu_result[1:0]
//   is_unsigned in  1   zero-extend instead of sign-extend
//   load_val    out 32  aligned, extended load value
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // Halfword lane is chosen by offset[1] only; offset[0] is ignored.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: load_val = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            SZ_HALF: load_val = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            default: load_val = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access stage of the 5-stage pipeline (EX/MEM -> MEM/WB). Issues
// data-memory requests, builds store byte enables and lane-replicated store
// data, aligns/extends load data, and stalls upstream while an access is in
// flight. A BUSY access with no dmem_ack for TIMEOUT_CYC cycles is aborted.
//   clk, rst            clock; asynchronous active-high reset
//   valid .. dst        EX/MEM latch contents (held stable while stall=1)
//   dmem                data-memory bus (mem_access_stage_if.master)
//   stall               hold EX/MEM and earlier stages
//   *_out               values presented to the MEM/WB latch
//   bus_err             one-cycle pulse on an aborted access
// Build option: define MEM_MISALIGN_TRAP_EN to abort misaligned half/word
// accesses without touching memory.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int DATA_W      = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        dst,
    mem_access_stage_if.master dmem,
    output logic              stall,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] data_load_out,
    output logic [4:0]        dst_out,
    output logic              bus_err
);

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [31:0] load_q;
    logic [31:0] load_val;
    logic        abort_q, abort_nx;
    logic        bus_err_nx;
    logic        mem_op;
    logic        misalign;
    logic        timeout_hit;
    logic [1:0]  offset;
    logic [1:0]  eff_size;

    assign offset      = alu_result[1:0];
    assign eff_size    = effective_size(mem_size);
    assign mem_op      = valid & (mem_read | mem_write);
    assign timeout_hit = (cnt == 8'(TIMEOUT_CYC - 1));

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((eff_size == SZ_HALF) && offset[0]) ||
                      ((eff_size == SZ_WORD) && (offset != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    mem_load_align u_load_align (
        .rdata       (dmem.dmem_rdata),
        .size        (eff_size),
        .offset      (offset),
        .is_unsigned (mem_unsigned),
        .load_val    (load_val)
    );

    // Fields that are not gated by the FSM pass straight through.
    assign mem_to_reg_out = mem_to_reg;
    assign alu_result_out = alu_result;
    assign dst_out        = dst;
    assign dmem.dmem_addr = {alu_result[31:2], 2'b00};

    // Store lanes; loads always enable the whole word. A combined
    // read+write is a store, so mem_write alone selects the lane pattern.
    always_comb begin
        dmem.dmem_be    = BE_WORD;
        dmem.dmem_wdata = store_data;
        if (mem_write) begin
            case (eff_size)
                SZ_BYTE: begin
                    dmem.dmem_be    = BE_BYTE0 << offset;
                    dmem.dmem_wdata = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    dmem.dmem_be    = offset[1] ? BE_HI_HALF : BE_LO_HALF;
                    dmem.dmem_wdata = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            load_q  <= 32'd0;
            abort_q <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_nx;
            abort_q <= abort_nx;
            bus_err <= bus_err_nx;
            if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end else if (state == DONE) begin
                cnt <= 8'd0;
            end
            if ((state == BUSY) && dmem.dmem_ack) begin
                load_q <= load_val;
            end
        end
    end

    // dmem_req comes straight from the state register, so it is glitch-free
    // and drops the instant rst is asserted.
    always_comb begin
        state_nx       = state;
        abort_nx       = abort_q;
        bus_err_nx     = 1'b0;
        stall          = 1'b0;
        reg_write_out  = 1'b0;
        data_load_out  = 32'd0;
        dmem.dmem_req  = 1'b0;
        dmem.dmem_we   = 1'b0;
        case (state)
            IDLE: begin
                reg_write_out = valid & reg_write;
                if (mem_op) begin
                    stall         = 1'b1;
                    reg_write_out = 1'b0;
                    if (misalign) begin
                        state_nx   = DONE;
                        abort_nx   = 1'b1;
                        bus_err_nx = 1'b1;
                    end else begin
                        state_nx = BUSY;
                        abort_nx = 1'b0;
                    end
                end
            end
            BUSY: begin
                stall         = 1'b1;
                dmem.dmem_req = 1'b1;
                dmem.dmem_we  = mem_write;
                // Ack wins over a coincident timeout.
                if (dmem.dmem_ack) begin
                    state_nx = DONE;
                    abort_nx = 1'b0;
                end else if (timeout_hit) begin
                    state_nx   = DONE;
                    abort_nx   = 1'b1;
                    bus_err_nx = 1'b1;
                end
            end
            DONE: begin
                reg_write_out = valid & reg_write & ~abort_q;
                data_load_out = load_q;
                state_nx      = IDLE;
                abort_nx      = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed plus randomized bench for mem_access_stage built with
// TIMEOUT_CYC=4. A behavioural model computes expected lanes, load values,
// stall lengths and abort outcomes. Define MEM_MISALIGN_TRAP_EN to build
// against the trapping variant.
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid, mem_read, mem_write, mem_unsigned, reg_write, mem_to_reg;
    logic [1:0]  mem_size;
    logic [31:0] alu_result, store_data;
    logic [4:0]  dst;
    logic        stall, reg_write_out, mem_to_reg_out, bus_err;
    logic [31:0] alu_result_out, data_load_out;
    logic [4:0]  dst_out;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] last_load = 32'd0;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.TIMEOUT_CYC(TIMEOUT), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid          (valid),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .dst            (dst),
        .dmem           (dmem_bus.master),
        .stall          (stall),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .alu_result_out (alu_result_out),
        .data_load_out  (data_load_out),
        .dst_out        (dst_out),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] refLoad(input logic [31:0] rdata, input logic [1:0] sz,
                                            input logic [1:0] a, input logic uns);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rdata >> (8 * a)) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rdata >> ((a >= 2'd2) ? 16 : 0)) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic refMisaligned(input logic [1:0] sz, input logic [1:0] a);
        return TRAP && (((sz == 2'b01) && (a % 2 == 1)) || ((sz == 2'b10) && (a != 0)));
    endfunction

    // Non-memory op or bubble: zero-latency, one cycle, DUT stays in IDLE.
    task automatic applyPassthrough(input logic v, input logic rw, input logic m2r,
                                    input logic [31:0] addr, input logic [4:0] d);
        valid = v; reg_write = rw; mem_to_reg = m2r; alu_result = addr; dst = d;
        mem_read = v ? 1'b0 : 1'($urandom_range(0, 1));
        mem_write = v ? 1'b0 : 1'($urandom_range(0, 1));
        mem_size = 2'($urandom_range(0, 3)); store_data = $urandom;
        dmem_bus.dmem_ack = 1'($urandom_range(0, 1));
        dmem_bus.dmem_rdata = $urandom;
        @(negedge clk);
        checkOutput("pt_stall", stall, 0);
        checkOutput("pt_rw", reg_write_out, v & rw);
        checkOutput("pt_m2r", mem_to_reg_out, m2r);
        checkOutput("pt_alu", alu_result_out, addr);
        checkOutput("pt_dst", dst_out, d);
        checkOutput("pt_load", data_load_out, 0);
        checkOutput("pt_req", dmem_bus.dmem_req, 0);
        checkOutput("pt_err", bus_err, 0);
        tick();
        dmem_bus.dmem_ack = 1'b0;
    endtask

    // Full memory access from IDLE through DONE. ack_at is the BUSY cycle
    // (1-based) in which the memory acks; 0 or beyond TIMEOUT means never.
    task automatic applyStimulus(input logic is_rd, input logic is_wr, input logic [1:0] sz,
                                 input logic uns, input logic rw, input logic m2r,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [4:0] d, input int ack_at, input logic [31:0] rdata);
        logic [1:0]  a;
        logic [1:0]  esz;
        logic        mis;
        logic        acked;
        logic        ok;
        int          nbusy;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        a      = addr[1:0];
        esz    = (sz == 2'b11) ? 2'b10 : sz;
        mis    = refMisaligned(esz, a);
        acked  = !mis && (ack_at >= 1) && (ack_at <= TIMEOUT);
        ok     = acked;
        nbusy  = mis ? 0 : (acked ? ack_at : TIMEOUT);
        exp_be = 4'hF;
        exp_wd = sd;
        if (is_wr && esz == 2'b00) begin
            exp_be = 4'(1 << a);
            exp_wd = 32'h0101_0101 * {24'd0, sd[7:0]};
        end else if (is_wr && esz == 2'b01) begin
            exp_be = (a >= 2'd2) ? 4'hC : 4'h3;
            exp_wd = 32'h0001_0001 * {16'd0, sd[15:0]};
        end

        valid = 1'b1; mem_read = is_rd; mem_write = is_wr; mem_size = sz;
        mem_unsigned = uns; reg_write = rw; mem_to_reg = m2r;
        alu_result = addr; store_data = sd; dst = d;
        dmem_bus.dmem_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_stall", stall, 1);
        checkOutput("idle_req", dmem_bus.dmem_req, 0);
        checkOutput("idle_rw", reg_write_out, 0);
        tick();

        for (int k = 1; k <= nbusy; k++) begin
            dmem_bus.dmem_ack   = (k == ack_at);
            dmem_bus.dmem_rdata = (k == ack_at) ? rdata : $urandom;
            @(negedge clk);
            checkOutput("busy_req", dmem_bus.dmem_req, 1);
            checkOutput("busy_we", dmem_bus.dmem_we, is_wr);
            checkOutput("busy_addr", dmem_bus.dmem_addr, addr & 32'hFFFF_FFFC);
            checkOutput("busy_be", dmem_bus.dmem_be, exp_be);
            if (is_wr) checkOutput("busy_wdata", dmem_bus.dmem_wdata, exp_wd);
            checkOutput("busy_stall", stall, 1);
            checkOutput("busy_rw", reg_write_out, 0);
            checkOutput("busy_err", bus_err, 0);
            tick();
        end

        if (acked) last_load = refLoad(rdata, esz, a, uns);
        dmem_bus.dmem_ack = 1'($urandom_range(0, 1));
        dmem_bus.dmem_rdata = $urandom;
        @(negedge clk);
        checkOutput("done_stall", stall, 0);
        checkOutput("done_req", dmem_bus.dmem_req, 0);
        checkOutput("done_rw", reg_write_out, rw & ok);
        checkOutput("done_err", bus_err, !ok);
        checkOutput("done_alu", alu_result_out, addr);
        checkOutput("done_dst", dst_out, d);
        checkOutput("done_m2r", mem_to_reg_out, m2r);
        checkOutput("done_load", data_load_out, last_load);
        tick();
        dmem_bus.dmem_ack = 1'b0;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        checkOutput("after_err", bus_err, 0);
        checkOutput("after_stall", stall, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00;
        mem_unsigned = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        alu_result = 32'd0; store_data = 32'd0; dst = 5'd0;
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'd0;

        // Reset state
        #12;
        checkOutput("rst_req", dmem_bus.dmem_req, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_err", bus_err, 0);
        checkOutput("rst_rw", reg_write_out, 0);
        checkOutput("rst_load", data_load_out, 0);
        rst = 1'b0;
        tick();

        // ADD pass-through and a bubble
        applyPassthrough(1'b1, 1'b1, 1'b0, 32'h0000_1234, 5'd5);
        applyPassthrough(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd7);

        // LB sign-extended, ack in 2nd BUSY cycle
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'd0,
                      5'd3, 2, 32'h80FF_FF01);
        checkOutput("lb_value", last_load, 32'hFFFF_FF80);
        // LHU
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 32'd0,
                      5'd4, 1, 32'hBEEF_1234);
        checkOutput("lhu_value", last_load, 32'h0000_BEEF);
        // SB at 0x101
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0000_0101, 32'hAABB_CCDD,
                      5'd0, 1, 32'h0);
        // Timeout: no ack at all
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'd0,
                      5'd9, 0, 32'h0);
        // Ack coincident with the timeout boundary is a success
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'd0,
                      5'd10, TIMEOUT, 32'h1357_9BDF);
        // Read+write together acts as a store; size 11 acts as word
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0BAD_F00D,
                      5'd0, 1, 32'h2468_ACE0);

        // Async reset in the middle of BUSY
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10;
        reg_write = 1'b1; alu_result = 32'h0000_0400; dst = 5'd11;
        dmem_bus.dmem_ack = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("mid_req", dmem_bus.dmem_req, 1);
        #2;
        rst = 1'b1;
        valid = 1'b0;
        #1;
        checkOutput("arst_req", dmem_bus.dmem_req, 0);
        checkOutput("arst_stall", stall, 0);
        checkOutput("arst_load", data_load_out, 0);
        #1;
        rst = 1'b0;
        last_load = 32'd0;
        tick();
        applyPassthrough(1'b1, 1'b1, 1'b1, 32'h0000_0040, 5'd12);

`ifdef MEM_MISALIGN_TRAP_EN
        // LW at 0x102 traps without a memory request
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'd0,
                      5'd13, 1, 32'h0);
`endif

        // Randomized mix of pass-throughs, bubbles, loads and stores
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                applyPassthrough(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 $urandom, 5'($urandom_range(0, 31)));
            end else if (kind == 1) begin
                applyPassthrough(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 $urandom, 5'($urandom_range(0, 31)));
            end else begin
                logic is_wr, is_rd;
                is_wr = (kind == 3);
                is_rd = is_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
                applyStimulus(is_rd, is_wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                              $urandom, 5'($urandom_range(0, 31)), $urandom_range(1, 6),
                              $urandom);
            end
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
